// File: rtl/stream_downsizer_if.sv
// Handshake bundle for stream_downsizer: one wide input stream, one narrow output stream.
`timescale 1ns/1ps
interface stream_downsizer_if #(
  parameter int unsigned OUT_WIDTH = 8,
  parameter int unsigned RATIO     = 4
);
  logic                         ready_in;
  logic                         valid_in;
  logic [RATIO*OUT_WIDTH-1:0]   data_in;
  logic                         ready_out;
  logic                         valid_out;
  logic [OUT_WIDTH-1:0]         data_out;
  logic                         last_out;

  // Downsizer side: consumes the wide stream, produces the narrow stream.
  modport slave (
    output ready_in,
    input  valid_in,
    input  data_in,
    input  ready_out,
    output valid_out,
    output data_out,
    output last_out
  );

  // Environment side: drives the wide stream and sinks the narrow stream.
  modport master (
    input  ready_in,
    output valid_in,
    output data_in,
    output ready_out,
    input  valid_out,
    input  data_out,
    input  last_out
  );
endinterface

// File: rtl/stream_downsizer.sv
// Ready/valid width down-converter: one RATIO*OUT_WIDTH word in, RATIO narrow beats out,
// least-significant slice first, last beat flagged. A held word can be replaced on its
// final beat so consecutive words stream without bubbles.
`timescale 1ns/1ps
module stream_downsizer #(
  parameter int unsigned OUT_WIDTH = 8,
  parameter int unsigned RATIO     = 4
) (
  input  logic                clk,
  input  logic                reset,
  stream_downsizer_if.slave   bus
);

  localparam int unsigned InWidth = RATIO * OUT_WIDTH;
  localparam int unsigned CntW    = (RATIO > 2) ? $clog2(RATIO) : 1;

  if (RATIO < 2) begin : g_bad_ratio
    $error("stream_downsizer: RATIO must be at least 2");
  end

  logic [InWidth-1:0] buf_q;
  logic               full_q;
  logic [CntW-1:0]    cnt_q;

  logic at_last;
  logic in_fire;
  logic out_fire;

  // Handshake decode; ready_in depends on ready_out so a new word lands on the last beat.
  always_comb begin
    at_last       = (cnt_q == CntW'(RATIO - 1));
    bus.valid_out = full_q & ~reset;
    out_fire      = bus.valid_out & bus.ready_out;
    bus.ready_in  = ~reset & (~full_q | (out_fire & at_last));
    in_fire       = bus.valid_in & bus.ready_in;
    bus.last_out  = full_q & at_last;
    bus.data_out  = buf_q[cnt_q*OUT_WIDTH +: OUT_WIDTH];
  end

  // Holding register, occupancy flag and beat index; full_q encodes EMPTY/HOLD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_q  <= '0;
      full_q <= 1'b0;
      cnt_q  <= '0;
    end else if (in_fire) begin
      // Covers both EMPTY accept and last-beat replacement while in HOLD.
      buf_q  <= bus.data_in;
      cnt_q  <= '0;
      full_q <= 1'b1;
    end else if (out_fire) begin
      if (at_last) begin
        // Explicit wrap keeps non-power-of-two RATIO in range.
        cnt_q  <= '0;
        full_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

endmodule

// File: tb/tb_stream_downsizer.sv
// Directed self-checking bench for stream_downsizer (OUT_WIDTH=8, RATIO=4).
// Observation vector per cycle: {valid_out, last_out, ready_in, data_out (0 when not valid)}.
`timescale 1ns/1ps
module tb_stream_downsizer;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  stream_downsizer_if #(.OUT_WIDTH(8), .RATIO(4)) bus ();

  stream_downsizer #(
    .OUT_WIDTH(8),
    .RATIO    (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // Drive one cycle's inputs at the falling edge and sample settled outputs 1ns later.
  task automatic run_cycle(input bit vin, input logic [31:0] din, input bit rout,
                           output logic [10:0] o, output bit fired);
    @(negedge clk);
    bus.valid_in  = vin;
    bus.data_in   = din;
    bus.ready_out = rout;
    #1;
    o     = {bus.valid_out, bus.last_out, bus.ready_in,
             (bus.valid_out === 1'b1) ? bus.data_out : 8'h00};
    fired = vin & (bus.ready_in === 1'b1);
  endtask

  task automatic test_reset;
    logic [10:0] raw;
    reset         = 1'b1;
    bus.valid_in  = 1'b1;
    bus.data_in   = 32'hFFFF_FFFF;
    bus.ready_out = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    raw = {bus.valid_out, bus.last_out, bus.ready_in, bus.data_out};
    tests++;
    if (raw !== 11'h000) begin
      fails++;
      $display("FAIL reset_held: got %h expected %h", raw, 11'h000);
    end
    bus.valid_in = 1'b0;
    reset        = 1'b0;
    #1;
    raw = {bus.valid_out, bus.last_out, bus.ready_in, 8'h00};
    tests++;
    if (raw !== 11'h100) begin
      fails++;
      $display("FAIL reset_release: got %h expected %h", raw, 11'h100);
    end
  endtask

  task automatic test_single;
    logic [10:0] exp [6] = '{11'h100, 11'h4AA, 11'h4BB, 11'h4CC, 11'h7DD, 11'h100};
    logic [10:0] o;
    bit          fired;
    int          idx = 0;
    for (int c = 0; c < 6; c++) begin
      run_cycle(idx < 1, 32'hDDCC_BBAA, 1'b1, o, fired);
      tests++;
      if (o !== exp[c]) begin
        fails++;
        $display("FAIL single cycle %0d: got %h expected %h", c, o, exp[c]);
      end
      if (fired) idx++;
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] words [2] = '{32'h0302_0100, 32'h0706_0504};
    logic [10:0] exp [10] = '{11'h100, 11'h400, 11'h401, 11'h402, 11'h703,
                              11'h404, 11'h405, 11'h406, 11'h707, 11'h100};
    logic [10:0] o;
    bit          fired;
    int          idx = 0;
    for (int c = 0; c < 10; c++) begin
      run_cycle(idx < 2, (idx < 2) ? words[idx] : 32'h0, 1'b1, o, fired);
      tests++;
      if (o !== exp[c]) begin
        fails++;
        $display("FAIL back_to_back cycle %0d: got %h expected %h", c, o, exp[c]);
      end
      if (fired) idx++;
    end
  endtask

  task automatic test_backpressure;
    bit          rout [9] = '{1, 1, 0, 0, 1, 1, 0, 1, 1};
    logic [10:0] exp [9] = '{11'h100, 11'h4AA, 11'h4BB, 11'h4BB, 11'h4BB,
                             11'h4CC, 11'h6DD, 11'h7DD, 11'h100};
    logic [10:0] o;
    bit          fired;
    int          idx = 0;
    for (int c = 0; c < 9; c++) begin
      run_cycle(idx < 1, 32'hDDCC_BBAA, rout[c], o, fired);
      tests++;
      if (o !== exp[c]) begin
        fails++;
        $display("FAIL backpressure cycle %0d: got %h expected %h", c, o, exp[c]);
      end
      if (fired) idx++;
    end
  endtask

  // Second word offered throughout word one, with a 5-cycle stall on the last beat.
  task automatic test_input_stall;
    logic [31:0] words [2] = '{32'hDDCC_BBAA, 32'h5566_7788};
    bit          rout [15] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
    logic [10:0] exp [15] = '{11'h100, 11'h4AA, 11'h4BB, 11'h4CC, 11'h6DD,
                              11'h6DD, 11'h6DD, 11'h6DD, 11'h6DD, 11'h7DD,
                              11'h488, 11'h477, 11'h466, 11'h755, 11'h100};
    logic [10:0] o;
    bit          fired;
    int          idx = 0;
    for (int c = 0; c < 15; c++) begin
      run_cycle(idx < 2, (idx < 2) ? words[idx] : 32'h0, rout[c], o, fired);
      tests++;
      if (o !== exp[c]) begin
        fails++;
        $display("FAIL input_stall cycle %0d: got %h expected %h", c, o, exp[c]);
      end
      if (fired) idx++;
    end
  endtask

  task automatic test_reset_midstream;
    logic [10:0] pre [4] = '{11'h100, 11'h4AA, 11'h4BB, 11'h4CC};
    bit          rout [4] = '{1, 1, 1, 0};
    logic [10:0] post [6] = '{11'h100, 11'h411, 11'h422, 11'h433, 11'h744, 11'h100};
    logic [10:0] o;
    logic [10:0] raw;
    bit          fired;
    int          idx = 0;
    for (int c = 0; c < 4; c++) begin
      run_cycle(idx < 1, 32'hDDCC_BBAA, rout[c], o, fired);
      tests++;
      if (o !== pre[c]) begin
        fails++;
        $display("FAIL reset_mid_pre cycle %0d: got %h expected %h", c, o, pre[c]);
      end
      if (fired) idx++;
    end
    // Word is held at beat 2; reset away from any clock edge.
    reset = 1'b1;
    #1;
    raw = {bus.valid_out, bus.last_out, bus.ready_in, bus.data_out};
    tests++;
    if (raw !== 11'h000) begin
      fails++;
      $display("FAIL reset_mid_async: got %h expected %h", raw, 11'h000);
    end
    @(negedge clk);
    reset        = 1'b0;
    bus.valid_in = 1'b0;
    #1;
    raw = {bus.valid_out, bus.last_out, bus.ready_in, 8'h00};
    tests++;
    if (raw !== 11'h100) begin
      fails++;
      $display("FAIL reset_mid_release: got %h expected %h", raw, 11'h100);
    end
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      run_cycle(idx < 1, 32'h4433_2211, 1'b1, o, fired);
      tests++;
      if (o !== post[c]) begin
        fails++;
        $display("FAIL reset_mid_post cycle %0d: got %h expected %h", c, o, post[c]);
      end
      if (fired) idx++;
    end
  endtask

  initial begin
    tests         = 0;
    fails         = 0;
    reset         = 1'b1;
    bus.valid_in  = 1'b0;
    bus.data_in   = '0;
    bus.ready_out = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_input_stall();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
